// File: rtl/maltsev_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : maltsev_pkg                                                     |
// | Purpose  : Shared constants and state encoding for the Maltsev-operation   |
// |            composition blocks (successor-unit arbiter and helpers).        |
// | Contents : default datapath width, requester-count limits, arbiter FSM     |
// |            state encoding.                                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package maltsev_pkg;

   // Datapath width of the S (successor) unit
   localparam int c_bw_default = 16;

   // Legal requester count range for the arbiter
   localparam int c_nreq_min = 2;
   localparam int c_nreq_max = 8;

   // Arbiter FSM encoding (binary)
   localparam logic [1:0] c_enc_idle   = 2'd0;
   localparam logic [1:0] c_enc_launch = 2'd1;
   localparam logic [1:0] c_enc_run    = 2'd2;
   localparam logic [1:0] c_enc_gap    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = c_enc_idle,
      S_LAUNCH = c_enc_launch,
      S_RUN    = c_enc_run,
      S_GAP    = c_enc_gap
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/operation_s_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operation_s_rr_pick                                             |
// | Purpose  : Combinational round-robin picker. Searches the pending mask     |
// |            starting at the pointer and wrapping modulo NREQ.               |
// | Ports    : i_pend  [NREQ-1:0]  pending requesters                          |
// |            i_ptr   [IW-1:0]    first index to consider                     |
// |            o_idx   [IW-1:0]    winning index (0 when none)                 |
// |            o_vld               at least one requester pending              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module operation_s_rr_pick
   import maltsev_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_pend,
   input  logic [IW-1:0]   i_ptr,
   output logic [IW-1:0]   o_idx,
   output logic            o_vld
);

   logic [IW:0]   w_sum;
   logic [IW-1:0] w_cand;

   // Scan from the farthest offset down to offset 0 so the candidate closest
   // to the pointer is the last (and therefore winning) assignment.
   always_comb begin
      o_idx  = '0;
      o_vld  = 1'b0;
      w_sum  = '0;
      w_cand = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, i_ptr} + (IW + 1)'(k);
         if (w_sum >= (IW + 1)'(NREQ)) begin
            w_sum = w_sum - (IW + 1)'(NREQ);
         end
         w_cand = w_sum[IW-1:0];
         if (i_pend[w_cand]) begin
            o_idx = w_cand;
            o_vld = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/operation_s_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : operation_s_arbiter                                             |
// | Purpose  : Shares one successor unit (RES = IN + 1) among NREQ requesters. |
// |            Requests are taken on ST rising edges, granted round-robin,     |
// |            sequenced through the unit's ST/RD handshake, and results are   |
// |            returned to per-requester registers. A stuck unit is aborted    |
// |            after TIMEOUT cycles in a wait state and flagged on ERR.        |
// | Ports    : CLK                 clock, posedge                              |
// |            RST                 asynchronous reset, active low              |
// |            ST    [NREQ]        per-requester start (0->1 edge)             |
// |            IN    [NREQ*BW]     per-requester operand                       |
// |            RD    [NREQ]        per-requester ready                         |
// |            RES   [NREQ*BW]     per-requester result                        |
// |            ERR   [NREQ]        per-requester timeout flag                  |
// |            U_ST, U_IN          start / operand to the S unit               |
// |            U_RD, U_RES         ready / result from the S unit              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module operation_s_arbiter
   import maltsev_pkg::*;
#(
   parameter int BW      = c_bw_default,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    ST,
   input  logic [NREQ*BW-1:0] IN,
   output logic [NREQ-1:0]    RD,
   output logic [NREQ*BW-1:0] RES,
   output logic [NREQ-1:0]    ERR,
   output logic               U_ST,
   output logic [BW-1:0]      U_IN,
   input  logic               U_RD,
   input  logic [BW-1:0]      U_RES
);

   localparam int             c_iw      = $clog2(NREQ);
   localparam int             c_cw      = $clog2(TIMEOUT + 1);
   localparam logic [c_cw-1:0] c_to_last = c_cw'(TIMEOUT - 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [c_cw-1:0]     r_cnt;
   logic                r_ust;
   logic [BW-1:0]       r_uin;
   logic [c_iw-1:0]     r_win;
   logic [c_iw-1:0]     r_ptr;
   logic [NREQ-1:0]     r_st_old;
   logic [NREQ-1:0]     r_rd;
   logic [NREQ-1:0]     r_err;
   logic [NREQ-1:0]     r_pend;
   logic [NREQ*BW-1:0]  r_res;
   logic [BW-1:0]       r_op [NREQ];

   logic [c_iw-1:0]     w_pick_idx;
   logic                w_pick_vld;
   logic [NREQ-1:0]     w_acc;
   logic                w_launch;
   logic                w_done;
   logic                w_abort;
   logic                w_cnt_clr;
   logic                w_cnt_inc;

   // A request is only taken while the port is ready, so edges arriving
   // during service (including the completion cycle) are dropped.
   assign w_acc = ST & ~r_st_old & r_rd;

   // r_pend excludes the requester currently in service; it is cleared at grant.
   operation_s_rr_pick #(
      .NREQ (NREQ),
      .IW   (c_iw)
   ) u_pick (
      .i_pend (r_pend),
      .i_ptr  (r_ptr),
      .o_idx  (w_pick_idx),
      .o_vld  (w_pick_vld)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pick_vld) begin
               w_launch    = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            // U_RD dropping means the unit has seen our ST edge
            if (!U_RD) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = S_RUN;
            end else if (r_cnt == c_to_last) begin
               w_abort     = 1'b1;
               w_state_nxt = S_GAP;
            end else begin
               w_cnt_inc   = 1'b1;
            end
         end
         S_RUN: begin
            if (U_RD) begin
               w_done      = 1'b1;
               w_state_nxt = S_GAP;
            end else if (r_cnt == c_to_last) begin
               w_abort     = 1'b1;
               w_state_nxt = S_GAP;
            end else begin
               w_cnt_inc   = 1'b1;
            end
         end
         S_GAP: begin
            // U_ST is already low here; this cycle lets the unit sample it
            // low before the next launch so it sees a clean rising edge.
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------- shared unit control
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_cnt <= '0;
         r_ust <= 1'b0;
         r_uin <= '0;
         r_win <= '0;
         r_ptr <= '0;
      end else begin
         if (w_cnt_clr) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_launch) begin
            r_ust <= 1'b1;
            r_uin <= r_op[w_pick_idx];
            r_win <= w_pick_idx;
         end else if (w_done || w_abort) begin
            r_ust <= 1'b0;
            r_ptr <= (r_win == c_iw'(NREQ - 1)) ? '0 : r_win + 1'b1;
         end
      end
   end

   // ------------------------------------------------ per-requester state
   // Accept and completion never target the same requester in one cycle
   // (accept needs RD=1, the served requester has RD=0), so both may fire.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_st_old <= '0;
         r_rd     <= '1;
         r_err    <= '0;
         r_pend   <= '0;
         r_res    <= '0;
         for (int i = 0; i < NREQ; i++) begin
            r_op[i] <= '0;
         end
      end else begin
         r_st_old <= ST;
         for (int i = 0; i < NREQ; i++) begin
            if (w_acc[i]) begin
               r_op[i]   <= IN[i*BW +: BW];
               r_err[i]  <= 1'b0;
               r_rd[i]   <= 1'b0;
               r_pend[i] <= 1'b1;
            end
            if (w_launch && (w_pick_idx == c_iw'(i))) begin
               r_pend[i] <= 1'b0;
            end
            if ((w_done || w_abort) && (r_win == c_iw'(i))) begin
               r_rd[i] <= 1'b1;
               if (w_done) begin
                  r_res[i*BW +: BW] <= U_RES;
               end
               if (w_abort) begin
                  r_err[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign RD   = r_rd;
   assign RES  = r_res;
   assign ERR  = r_err;
   assign U_ST = r_ust;
   assign U_IN = r_uin;

endmodule
`default_nettype wire

// File: tb/tb_operation_s_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_operation_s_arbiter                                          |
// | Purpose  : Directed self-checking bench for operation_s_arbiter with a     |
// |            behavioural successor unit (RES = IN + 1) that can be delayed   |
// |            or held stuck with U_RD high.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_operation_s_arbiter;

   localparam int BW      = 16;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 15;

   logic               CLK = 1'b0;
   logic               RST;
   logic [NREQ-1:0]    ST;
   logic [NREQ*BW-1:0] IN;
   logic [NREQ-1:0]    RD;
   logic [NREQ*BW-1:0] RES;
   logic [NREQ-1:0]    ERR;
   logic               U_ST;
   logic [BW-1:0]      U_IN;
   logic               U_RD;
   logic [BW-1:0]      U_RES;

   int n_cmp = 0;
   int n_bad = 0;

   // successor unit model controls
   int   u_delay = 1;
   logic u_stuck = 1'b0;
   int   u_busy;
   logic u_st_old;

   // completion tracking
   int ord [4];
   int got;
   int ust_rises;
   int cyc;

   always #5 CLK = ~CLK;

   operation_s_arbiter #(
      .BW      (BW),
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .ST    (ST),
      .IN    (IN),
      .RD    (RD),
      .RES   (RES),
      .ERR   (ERR),
      .U_ST  (U_ST),
      .U_IN  (U_IN),
      .U_RD  (U_RD),
      .U_RES (U_RES)
   );

   // Behavioural S unit: accepts a ST rising edge while ready, drops RD,
   // and raises it again u_delay cycles later with IN + 1.
   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         U_RD     <= 1'b1;
         U_RES    <= '0;
         u_st_old <= 1'b0;
         u_busy   <= 0;
      end else begin
         u_st_old <= U_ST;
         if (!u_stuck) begin
            if (U_ST && !u_st_old && U_RD) begin
               U_RD   <= 1'b0;
               U_RES  <= U_IN + 16'd1;
               u_busy <= u_delay;
            end else if (!U_RD) begin
               if (u_busy <= 1) U_RD <= 1'b1;
               else             u_busy <= u_busy - 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for RD[idx] to rise; cyc reports cycles spent.
   task automatic wait_rd(input int idx, input int bound);
      cyc = 0;
      while (!RD[idx] && cyc < bound) begin
         tick();
         cyc++;
      end
      chk("wait_rd_bound", {31'd0, RD[idx]}, 32'd1);
   endtask

   // Record the order in which RD bits rise and count U_ST launches.
   task automatic collect(input int n, input int bound);
      logic [NREQ-1:0] prev_rd;
      logic            prev_ust;
      got       = 0;
      ust_rises = 0;
      prev_rd   = RD;
      prev_ust  = U_ST;
      for (int c = 0; c < bound && got < n; c++) begin
         tick();
         if (U_ST && !prev_ust) ust_rises++;
         for (int j = 0; j < NREQ; j++) begin
            if (RD[j] && !prev_rd[j]) begin
               if (got < 4) ord[got] = j;
               got++;
            end
         end
         prev_rd  = RD;
         prev_ust = U_ST;
      end
      chk("collect_count", got, n);
   endtask

   initial begin
      RST = 1'b0;
      ST  = '0;
      IN  = '0;
      tick();
      tick();
      // ---- reset state
      chk("rst_rd",   {28'd0, RD},  32'hF);
      chk("rst_err",  {28'd0, ERR}, 32'h0);
      chk("rst_res_lo", RES[31:0],  32'h0);
      chk("rst_res_hi", RES[63:32], 32'h0);
      chk("rst_ust",  {31'd0, U_ST}, 32'h0);
      chk("rst_uin",  {16'd0, U_IN}, 32'h0);
      RST = 1'b1;
      tick();

      // ---- contention: all four at once, ptr=0 -> order 0,1,2,3
      IN = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
      ST = 4'hF;
      collect(4, 60);
      chk("cont_ord0", ord[0], 0);
      chk("cont_ord1", ord[1], 1);
      chk("cont_ord2", ord[2], 2);
      chk("cont_ord3", ord[3], 3);
      chk("cont_res0", {16'd0, RES[0*BW +: BW]}, 32'h0001);
      chk("cont_res1", {16'd0, RES[1*BW +: BW]}, 32'h0011);
      chk("cont_res2", {16'd0, RES[2*BW +: BW]}, 32'h0021);
      chk("cont_res3", {16'd0, RES[3*BW +: BW]}, 32'h0031);
      chk("cont_launches", ust_rises, 4);
      ST = '0;
      tick();
      tick();

      // ---- single request, idle arbiter: RD low after accept, high 4 cycles later
      IN[0*BW +: BW] = 16'h0041;
      ST[0] = 1'b1;
      tick();
      chk("single_rd_low", {31'd0, RD[0]}, 32'd0);
      tick();
      chk("single_ust", {31'd0, U_ST}, 32'd1);
      tick();
      tick();
      chk("single_rd_still_low", {31'd0, RD[0]}, 32'd0);
      tick();
      chk("single_rd_high", {31'd0, RD[0]}, 32'd1);
      chk("single_res", {16'd0, RES[0*BW +: BW]}, 32'h0042);
      chk("single_err", {31'd0, ERR[0]}, 32'd0);
      ST = '0;
      tick();
      tick();

      // ---- wrap: FFFF + 1 = 0000 from the unit
      IN[2*BW +: BW] = 16'hFFFF;
      ST[2] = 1'b1;
      tick();
      wait_rd(2, 12);
      chk("wrap_res", {16'd0, RES[2*BW +: BW]}, 32'h0000);
      chk("wrap_err", {31'd0, ERR[2]}, 32'd0);
      ST = '0;
      tick();
      tick();

      // ---- fairness: serve 1 (ptr -> 2), then 0 and 3 together -> 3 first
      IN[1*BW +: BW] = 16'h0100;
      ST[1] = 1'b1;
      tick();
      wait_rd(1, 12);
      chk("fair_res1", {16'd0, RES[1*BW +: BW]}, 32'h0101);
      ST = '0;
      tick();
      tick();
      IN[0*BW +: BW] = 16'h0200;
      IN[3*BW +: BW] = 16'h0300;
      ST = 4'b1001;
      collect(2, 30);
      chk("fair_first",  ord[0], 3);
      chk("fair_second", ord[1], 0);
      chk("fair_res3", {16'd0, RES[3*BW +: BW]}, 32'h0301);
      chk("fair_res0", {16'd0, RES[0*BW +: BW]}, 32'h0201);
      ST = '0;
      tick();
      tick();

      // ---- timeout: unit never drops U_RD
      u_stuck = 1'b1;
      IN[1*BW +: BW] = 16'h0500;
      ST[1] = 1'b1;
      tick();
      wait_rd(1, 40);
      chk("to_not_early", {31'd0, (cyc >= TIMEOUT)}, 32'd1);
      chk("to_err", {31'd0, ERR[1]}, 32'd1);
      chk("to_res_kept", {16'd0, RES[1*BW +: BW]}, 32'h0101);
      chk("to_ust_low", {31'd0, U_ST}, 32'd0);
      u_stuck = 1'b0;
      ST = '0;
      tick();
      tick();
      IN[1*BW +: BW] = 16'h0600;
      ST[1] = 1'b1;
      tick();
      chk("to_err_cleared", {31'd0, ERR[1]}, 32'd0);
      wait_rd(1, 12);
      chk("to_retry_res", {16'd0, RES[1*BW +: BW]}, 32'h0601);
      chk("to_retry_err", {31'd0, ERR[1]}, 32'd0);
      ST = '0;
      tick();
      tick();

      // ---- asynchronous reset while in RUN
      u_delay = 20;
      IN[3*BW +: BW] = 16'h0700;
      ST[3] = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk("rrun_ust_high", {31'd0, U_ST}, 32'd1);
      chk("rrun_rd_low", {31'd0, RD[3]}, 32'd0);
      RST = 1'b0;
      #1;
      chk("rrun_rd_all", {28'd0, RD}, 32'hF);
      chk("rrun_ust_low", {31'd0, U_ST}, 32'd0);
      ST = '0;
      u_delay = 1;
      tick();
      RST = 1'b1;
      tick();
      IN[3*BW +: BW] = 16'h0800;
      ST[3] = 1'b1;
      tick();
      wait_rd(3, 12);
      chk("post_rst_res", {16'd0, RES[3*BW +: BW]}, 32'h0801);
      chk("post_rst_err", {31'd0, ERR[3]}, 32'd0);
      ST = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
`default_nettype wire
